// File: rtl/proc_trace_checker.sv
// proc_trace_checker: checks processor commit trace against a queue of expected (addr, data) records.
// Optional macro PROC_TRACE_CHECK_DCARE_EN adds a per-entry data don't-care bit (exp_dcare).
module proc_trace_checker #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exp_val,
    output logic        exp_rdy,
    input  logic [31:0] exp_addr,
    input  logic [31:0] exp_data,
`ifdef PROC_TRACE_CHECK_DCARE_EN
    input  logic        exp_dcare,
`endif
    input  logic        start,
    input  logic        trace_val,
    input  logic [31:0] trace_addr,
    input  logic [31:0] trace_data,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [7:0]  err_count,
    output logic [15:0] first_err_idx,
    output logic [31:0] first_err_addr
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        r_state, w_next;
    logic [31:0]   r_mem_addr [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic [15:0]   r_commit_idx;
    logic [TW-1:0] r_to_cnt;
    logic          r_done, r_pass, r_timeout;
    logic [7:0]    r_err_count;
    logic [15:0]   r_first_err_idx;
    logic [31:0]   r_first_err_addr;
    logic          w_exp_rdy, w_push, w_commit, w_extra, w_mis, w_err, w_last, w_expire, w_dcare;

`ifdef PROC_TRACE_CHECK_DCARE_EN
    logic r_mem_dcare [DEPTH];
    always_ff @(posedge clk)
        if (w_push) r_mem_dcare[r_wr_ptr] <= exp_dcare;
    assign w_dcare = r_mem_dcare[r_rd_ptr];
`else
    assign w_dcare = 1'b0;
`endif

    always_ff @(posedge clk)
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= exp_addr;
            r_mem_data[r_wr_ptr] <= exp_data;
        end

    always_ff @(posedge clk)
        r_state <= rst ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && start) w_next = (r_count != '0) ? RUN : DONE;
        if (w_last || w_expire) w_next = DONE;
    end

    always_comb begin
        w_exp_rdy = (r_state == IDLE) && (r_count != CNT_FULL);
        w_push    = exp_val && w_exp_rdy;
        w_commit  = (r_state == RUN) && trace_val;
        w_extra   = (r_state == DONE) && trace_val;
        w_mis     = (trace_addr != r_mem_addr[r_rd_ptr]) ||
                    (!w_dcare && trace_data != r_mem_data[r_rd_ptr]);
        w_err     = (w_commit && w_mis) || w_extra;
        w_last    = w_commit && (r_count == CNT_ONE);
        w_expire  = (r_state == RUN) && !trace_val && (r_to_cnt == TO_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_commit_idx     <= '0;
            r_to_cnt         <= '0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_timeout        <= 1'b0;
            r_err_count      <= '0;
            r_first_err_idx  <= '0;
            r_first_err_addr <= '0;
        end else begin
            // a timeout discards whatever entries remain
            r_wr_ptr     <= w_expire ? '0 : w_push ? r_wr_ptr + PTR_ONE : r_wr_ptr;
            r_rd_ptr     <= w_expire ? '0 : w_commit ? r_rd_ptr + PTR_ONE : r_rd_ptr;
            r_count      <= w_expire ? '0 : w_push ? r_count + CNT_ONE : w_commit ? r_count - CNT_ONE : r_count;
            r_commit_idx <= w_commit ? r_commit_idx + 16'd1 : r_commit_idx;
            r_to_cnt     <= (trace_val || r_state != RUN) ? '0 : r_to_cnt + TO_ONE;
            r_done       <= (w_next == DONE);
            r_timeout    <= r_timeout || w_expire;
            r_err_count  <= (w_err && r_err_count != 8'hFF) ? r_err_count + 8'd1 : r_err_count;
            if (w_err && r_err_count == '0) begin
                r_first_err_idx  <= r_commit_idx;
                r_first_err_addr <= trace_addr;
            end
            if (r_state == IDLE && start && r_count == '0) r_pass <= 1'b1;
            if (w_last) r_pass <= (r_err_count == '0) && !w_mis;
            if (w_extra || w_expire) r_pass <= 1'b0;
        end
    end

    assign exp_rdy        = w_exp_rdy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign timeout        = r_timeout;
    assign err_count      = r_err_count;
    assign first_err_idx  = r_first_err_idx;
    assign first_err_addr = r_first_err_addr;
endmodule

// File: tb/tb_proc_trace_checker.sv
// tb_proc_trace_checker: directed self-checking bench for proc_trace_checker (DEPTH=4, TIMEOUT=8).
module tb_proc_trace_checker;
    logic        clk = 1'b0;
    logic        rst, exp_val, start, trace_val;
    logic [31:0] exp_addr, exp_data, trace_addr, trace_data;
    logic        exp_rdy, done, pass, timeout;
    logic [7:0]  err_count;
    logic [15:0] first_err_idx;
    logic [31:0] first_err_addr;
`ifdef PROC_TRACE_CHECK_DCARE_EN
    logic        exp_dcare = 1'b0;
`endif
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    proc_trace_checker #(.DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .exp_val(exp_val), .exp_rdy(exp_rdy),
        .exp_addr(exp_addr), .exp_data(exp_data),
`ifdef PROC_TRACE_CHECK_DCARE_EN
        .exp_dcare(exp_dcare),
`endif
        .start(start), .trace_val(trace_val), .trace_addr(trace_addr), .trace_data(trace_data),
        .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_addr(first_err_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        exp_val = 1'b1; exp_addr = a; exp_data = d;
        step();
        exp_val = 1'b0;
    endtask

    task automatic commit(input logic [31:0] a, input logic [31:0] d);
        trace_val = 1'b1; trace_addr = a; trace_data = d;
        step();
        trace_val = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".exp_rdy"}, 32'(exp_rdy), 32'd1);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".pass"}, 32'(pass), 32'd0);
        chk({tag, ".timeout"}, 32'(timeout), 32'd0);
        chk({tag, ".err"}, 32'(err_count), 32'd0);
        chk({tag, ".idx"}, 32'(first_err_idx), 32'd0);
        chk({tag, ".addr"}, first_err_addr, 32'd0);
    endtask

    initial begin
        exp_val = 0; start = 0; trace_val = 0;
        exp_addr = 0; exp_data = 0; trace_addr = 0; trace_data = 0;
        do_reset();
        chk_reset_outputs("rst");

        // all three commits match
        push(32'h200, 5); push(32'h204, 7); push(32'h208, 12);
        do_start();
        chk("run.exp_rdy", 32'(exp_rdy), 32'd0);
        commit(32'h200, 5); commit(32'h204, 7);
        chk("match.done_early", 32'(done), 32'd0);
        commit(32'h208, 12);
        chk("match.done", 32'(done), 32'd1);
        chk("match.pass", 32'(pass), 32'd1);
        chk("match.err", 32'(err_count), 32'd0);

        // second commit data wrong
        do_reset();
        push(32'h200, 5); push(32'h204, 7); push(32'h208, 12);
        do_start();
        commit(32'h200, 5); commit(32'h204, 8); commit(32'h208, 12);
        chk("mis.done", 32'(done), 32'd1);
        chk("mis.pass", 32'(pass), 32'd0);
        chk("mis.err", 32'(err_count), 32'd1);
        chk("mis.idx", 32'(first_err_idx), 32'd1);
        chk("mis.addr", first_err_addr, 32'h204);

        // timeout exactly 8 cycles after the last commit
        do_reset();
        push(32'h200, 5); push(32'h204, 7);
        do_start();
        commit(32'h200, 5);
        for (int i = 0; i < 7; i++) step();
        chk("to.early_done", 32'(done), 32'd0);
        chk("to.early_timeout", 32'(timeout), 32'd0);
        step();
        chk("to.timeout", 32'(timeout), 32'd1);
        chk("to.done", 32'(done), 32'd1);
        chk("to.pass", 32'(pass), 32'd0);
        chk("to.err", 32'(err_count), 32'd0);

        // full queue, refused fifth push, extra commit in DONE
        do_reset();
        for (int i = 0; i < 4; i++) push(32'h300 + 32'(4 * i), 32'(i + 1));
        chk("full.exp_rdy", 32'(exp_rdy), 32'd0);
        push(32'h400, 99);
        chk("full.exp_rdy2", 32'(exp_rdy), 32'd0);
        do_start();
        for (int i = 0; i < 4; i++) commit(32'h300 + 32'(4 * i), 32'(i + 1));
        chk("full.done", 32'(done), 32'd1);
        chk("full.pass", 32'(pass), 32'd1);
        commit(32'h500, 1);
        chk("extra.err", 32'(err_count), 32'd1);
        chk("extra.pass", 32'(pass), 32'd0);
        chk("extra.idx", 32'(first_err_idx), 32'd4);
        chk("extra.addr", first_err_addr, 32'h500);

        // start with empty queue passes immediately
        do_reset();
        do_start();
        chk("empty.done", 32'(done), 32'd1);
        chk("empty.pass", 32'(pass), 32'd1);

        // trace_val coinciding with start is ignored
        do_reset();
        push(32'h600, 3);
        start = 1'b1; trace_val = 1'b1; trace_addr = 32'h600; trace_data = 3;
        step();
        start = 1'b0; trace_val = 1'b0;
        chk("st_tv.done", 32'(done), 32'd0);
        commit(32'h600, 3);
        chk("st_tv.pass", 32'(pass), 32'd1);

        // reset mid-RUN after an error
        do_reset();
        push(32'h700, 1); push(32'h704, 2);
        do_start();
        commit(32'h700, 9);
        chk("midrst.err", 32'(err_count), 32'd1);
        rst = 1'b1;
        step();
        chk_reset_outputs("midrst");
        rst = 1'b0;

`ifdef PROC_TRACE_CHECK_DCARE_EN
        do_reset();
        exp_dcare = 1'b1;
        push(32'h20C, 0);
        exp_dcare = 1'b0;
        do_start();
        commit(32'h20C, 32'hDEADBEEF);
        chk("dcare.done", 32'(done), 32'd1);
        chk("dcare.pass", 32'(pass), 32'd1);
        rst = 1'b1;
        step();
        chk_reset_outputs("dcare_rst");
        rst = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/proc_trace_checker.md
# proc_trace_checker

Synthesizable commit-trace checker for processor tests. It holds a queue of expected (addr, data) commit records, arms on `start`, and compares each committed instruction reported on the processor trace port against the queue head in order. It reports pass/fail, error counts, the first mismatch, and a no-commit timeout. It sits beside any processor variant (FL, single-cycle, pipelined) and replaces per-commit checking done in bench tasks, so a processor can self-check in simulation or on FPGA.

## Interface
Parameters:
- `DEPTH`, 16: expected-record queue entries; power of two, at least 2.
- `TIMEOUT`, 256: maximum consecutive armed cycles without `trace_val` before failing; at least 1.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `exp_val` in 1: expected-record push valid.
- `exp_rdy` out 1: push ready; equals (state==IDLE) && !full.
- `exp_addr` in 32: expected commit PC.
- `exp_data` in 32: expected commit data.
- `start` in 1: arm the checker; sampled in IDLE only.
- `trace_val` in 1: processor committed an instruction this cycle.
- `trace_addr` in 32: committed PC.
- `trace_data` in 32: committed writeback/store data.
- `done` out 1: checking finished; held until reset.
- `pass` out 1: valid when `done`; 1 means zero errors and no timeout.
- `timeout` out 1: timeout occurred.
- `err_count` out 8: mismatches plus extra commits; saturates at 255.
- `first_err_idx` out 16: commit index (0-based) of first error.
- `first_err_addr` out 32: `trace_addr` of first error.

## Operation
- State machine IDLE → RUN → DONE. DONE exits only on `rst`.
- IDLE: a push occurs when `exp_val && exp_rdy`. Writes {addr, data} at tail, and the count increments. `start` with count>0 → RUN. `start` with count==0 → DONE, pass=1.
- RUN: on `trace_val`, the head is compared and popped. Mismatch means addr differs or data differs. A mismatch increments `err_count`.
- RUN, `trace_val` with queue empty is impossible by construction, because RUN exits when the queue empties.
- A commit index counter increments on every RUN commit.
- First error (`err_count`==0 before the update) latches `first_err_idx` and `first_err_addr`. Later errors do not overwrite them.
- RUN → DONE in the cycle the final entry pops (count goes 1→0). `pass` = no errors including that final compare.
- In DONE, any `trace_val` is an extra commit and increments `err_count` (saturating). `pass` drops to 0 if it was 1. `first_err_*` latch if no earlier error.
- Timeout counter: clears on every `trace_val` and on entry to RUN, and increments in RUN otherwise. Reaching TIMEOUT → DONE with `timeout`=1 and `pass`=0, and remaining entries are discarded.
- `start` asserted outside IDLE is ignored. Pushes are refused outside IDLE (`exp_rdy`=0). When full, `exp_rdy`=0 and `exp_val` is ignored.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.

## Timing
- All outputs are registered. Reset values: `exp_rdy` reads 1 (IDLE, empty), and every other output is 0. Queue pointers, count, commit index, and timeout counter are all 0.
- A push is visible to compare no earlier than the RUN entry cycle: one cycle after `start` is sampled.
- Compare latency is 1 cycle. `err_count`, `first_err_*`, `done`, and `pass` reflect a commit at edge N in the value read after edge N.
- A `trace_val` in the same cycle that `start` is sampled is ignored.
- Reset mid-RUN or in DONE takes effect at the next edge. The queue contents are abandoned and all outputs return to reset values.

## Configuration
- `PROC_TRACE_CHECK_DCARE_EN` defined: adds input `exp_dcare` (1 bit), stored per entry. When set, the data compare is skipped and only the address is checked. This matches bench checks whose expected data is don't-care (jumps, branches, no writeback).
- Undefined: the port and the storage bit are absent, and every entry compares both addr and data.

## Test plan
- Push (0x200,5),(0x204,7),(0x208,12); start; trace commits match on consecutive cycles → done=1, pass=1, err_count=0 the cycle after the third commit.
- Same queue, second commit data=8 → done=1, pass=0, err_count=1, first_err_idx=1, first_err_addr=0x204.
- TIMEOUT=8, push 2 entries, one matching commit then silence → timeout=1, done=1, pass=0 exactly 8 cycles after the last commit.
- DEPTH=4: push 5 records → exp_rdy=0 after the fourth; fifth not stored; start then 4 matching commits → pass=1; one more trace_val → err_count=1, pass=0.
- With `PROC_TRACE_CHECK_DCARE_EN`: entry (0x20C, dcare=1), commit data 0xDEADBEEF → pass=1; `rst` asserted mid-RUN → all outputs 0 and exp_rdy=1 next cycle.
